tx: RTL and testbench

- UART transmitter. Serialises parallel bytes onto `o_tx` as: start bit, `WIDTH_DATA` data bits LSB first, optional parity bit, `STOP_BITS` stop bits.
- Bit timing comes from an external baud clock `clk_tx`. Its rising edges are detected in the `i_clk` domain.
- A one-deep holding register lets the host queue the next byte while the current frame is shifting out, so frames go back-to-back.
- Sits beside the UART receiver and shares the same baud-generator style.

---
 rtl/tx_if.sv | 23 ++
 rtl/tx.sv | 165 ++++++++++++++++
 tb/tb_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_if.sv
// Host-side write bus of the UART transmitter: data, write strobe and status.
interface tx_if #(
    parameter int WIDTH_DATA = 8
);
    logic [WIDTH_DATA-1:0] i_data;
    logic                  i_we;
    logic                  o_rdy;
    logic                  o_busy;

    modport master (
        output i_data,
        output i_we,
        input  o_rdy,
        input  o_busy
    );

    modport slave (
        input  i_data,
        input  i_we,
        output o_rdy,
        output o_busy
    );
endinterface

// File: rtl/tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits,
// paced by rising edges of an external baud clock, with a one-deep holding register.
module tx #(
    parameter int WIDTH_DATA = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic clk_tx,
    tx_if.slave  bus,
    output logic o_srst_clk,
    output logic o_tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(WIDTH_DATA - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state_q, state_d;
    logic [1:0]            sample_q;
    logic                  ev_pe;
    logic                  valid_q, valid_d;
    logic [WIDTH_DATA-1:0] hold_q, hold_d;
    logic [WIDTH_DATA-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic                  stopcnt_q, stopcnt_d;
    logic                  tx_q, tx_d;
    logic                  srst_q, srst_d;
    logic                  xfer;

    function automatic logic parity_of(input logic [WIDTH_DATA-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    assign ev_pe = sample_q[0] & ~sample_q[1];

    // Frame sequencer; xfer moves the held byte into the shifter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        tx_d      = tx_q;
        srst_d    = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (valid_q) begin
                    xfer    = 1'b1;
                    srst_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (ev_pe) begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (ev_pe) begin
                    if (bitcnt_q != LAST_BIT) begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else if (PARITY != 0) begin
                        tx_d    = par_q;
                        state_d = PAR;
                    end else begin
                        tx_d      = 1'b1;
                        stopcnt_d = 1'b0;
                        state_d   = STOP;
                    end
                end
            end
            PAR: begin
                if (ev_pe) begin
                    tx_d      = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (ev_pe) begin
                    if (stopcnt_q != LAST_STOP) begin
                        stopcnt_d = stopcnt_q + 1'b1;
                    end else if (valid_q) begin
                        // Baud generator is already aligned, so no restart pulse here.
                        xfer    = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (xfer) begin
            shift_d = hold_q;
            par_d   = parity_of(hold_q);
        end
    end

    // A write in the transfer cycle is refused since o_rdy is still low.
    always_comb begin
        valid_d = valid_q;
        hold_d  = hold_q;
        if (xfer) begin
            valid_d = 1'b0;
        end else if (bus.i_we && !valid_q) begin
            valid_d = 1'b1;
            hold_d  = bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sample_q  <= 2'b00;
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            tx_q      <= 1'b1;
            srst_q    <= 1'b0;
        end else begin
            sample_q  <= {sample_q[0], clk_tx};
            state_q   <= state_d;
            valid_q   <= valid_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            tx_q      <= tx_d;
            srst_q    <= srst_d;
        end
    end

    always_ff @(posedge i_clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign bus.o_rdy  = ~valid_q;
    assign bus.o_busy = (state_q != IDLE) | valid_q;
    assign o_tx       = tx_q;
    assign o_srst_clk = srst_q;

endmodule

// File: tb/tb_tx.sv
// Scoreboard bench for tx: four configurations (8N1, 8E1, 8O1, 5N2) share one
// clock and one pausable baud clock; a monitor per instance decodes frames.
module tb_tx;

    logic i_clk = 1'b0;
    logic i_nrst = 1'b1;
    logic clk_tx = 1'b0;
    bit   run = 1'b1;
    int   div = 0;
    int   cyc = 0;
    int   rst_cnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    wire [3:0] line;
    wire [3:0] srst;

    int srst_cnt [4] = '{0, 0, 0, 0};
    int gap_cyc  [4] = '{0, 0, 0, 0};
    int end_cyc  [4] = '{0, 0, 0, 0};
    int flen     [4] = '{10, 11, 11, 8};
    int cfg_w    [4] = '{8, 8, 8, 5};
    int cfg_p    [4] = '{0, 1, 2, 0};
    int cfg_s    [4] = '{1, 1, 1, 2};
    logic [15:0] exp_q [4][$];

    always #5 i_clk = ~i_clk;

    // Baud clock: 16 system cycles per bit, frozen while run is clear.
    initial forever begin
        @(negedge i_clk);
        if (run) begin
            div++;
            if (div == 8) begin
                div    = 0;
                clk_tx = ~clk_tx;
            end
        end
    end

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (srst[0]) srst_cnt[0] <= srst_cnt[0] + 1;
        if (srst[1]) srst_cnt[1] <= srst_cnt[1] + 1;
        if (srst[2]) srst_cnt[2] <= srst_cnt[2] + 1;
        if (srst[3]) srst_cnt[3] <= srst_cnt[3] + 1;
    end

    always @(negedge i_nrst) rst_cnt <= rst_cnt + 1;

    tx_if #(.WIDTH_DATA(8)) b0 ();
    tx_if #(.WIDTH_DATA(8)) b1 ();
    tx_if #(.WIDTH_DATA(8)) b2 ();
    tx_if #(.WIDTH_DATA(5)) b3 ();

    tx #(.WIDTH_DATA(8), .STOP_BITS(1), .PARITY(0)) u0 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .bus(b0),
        .o_srst_clk(srst[0]), .o_tx(line[0]));
    tx #(.WIDTH_DATA(8), .STOP_BITS(1), .PARITY(1)) u1 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .bus(b1),
        .o_srst_clk(srst[1]), .o_tx(line[1]));
    tx #(.WIDTH_DATA(8), .STOP_BITS(1), .PARITY(2)) u2 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .bus(b2),
        .o_srst_clk(srst[2]), .o_tx(line[2]));
    tx #(.WIDTH_DATA(5), .STOP_BITS(2), .PARITY(0)) u3 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .bus(b3),
        .o_srst_clk(srst[3]), .o_tx(line[3]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Line bits in transmission order, bit 0 = start bit.
    function automatic logic [15:0] frame(input logic [7:0] data, input int w, input int par, input int stops);
        logic [15:0] f;
        logic        p;
        int          k;
        f = '0;
        p = 1'b0;
        k = 1;
        for (int i = 0; i < w; i++) begin
            f[k] = data[i];
            p    = p ^ data[i];
            k++;
        end
        if (par == 1) begin f[k] = p;  k++; end
        if (par == 2) begin f[k] = ~p; k++; end
        for (int i = 0; i < stops; i++) begin f[k] = 1'b1; k++; end
        return f;
    endfunction

    function automatic logic get_rdy(input int d);
        case (d)
            0: return b0.o_rdy;
            1: return b1.o_rdy;
            2: return b2.o_rdy;
            default: return b3.o_rdy;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return b0.o_busy;
            1: return b1.o_busy;
            2: return b2.o_busy;
            default: return b3.o_busy;
        endcase
    endfunction

    task automatic set_we(input int d, input logic [7:0] data, input logic we);
        case (d)
            0: begin b0.i_data = data;      b0.i_we = we; end
            1: begin b1.i_data = data;      b1.i_we = we; end
            2: begin b2.i_data = data;      b2.i_we = we; end
            default: begin b3.i_data = data[4:0]; b3.i_we = we; end
        endcase
    endtask

    task automatic wr(input int d, input logic [7:0] data, input bit push, input bit acc, input bit chk_rdy2);
        @(posedge i_clk); #1;
        check_eq($sformatf("rdy_before_wr%0d", d), get_rdy(d), acc);
        set_we(d, data, 1'b1);
        @(posedge i_clk); #1;
        set_we(d, data, 1'b0);
        if (acc) check_eq($sformatf("rdy_drop%0d", d), get_rdy(d), 1'b0);
        if (push) exp_q[d].push_back(frame(data, cfg_w[d], cfg_p[d], cfg_s[d]));
        if (chk_rdy2) begin
            @(posedge i_clk); #1;
            check_eq($sformatf("rdy_back%0d", d), get_rdy(d), 1'b1);
        end
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        check_eq($sformatf("drain%0d", d), exp_q[d].size(), 0);
    endtask

    // Frame decoder: samples each bit mid-period on the baud clock's falling edge.
    task automatic mon(input int d);
        logic [15:0] fr;
        logic [15:0] e;
        int          r0;
        forever begin
            fr = '0;
            do @(negedge i_clk); while (line[d] !== 1'b0);
            r0         = rst_cnt;
            gap_cyc[d] = cyc - end_cyc[d];
            if (clk_tx) @(negedge clk_tx);
            for (int i = 1; i < flen[d]; i++) begin
                @(negedge clk_tx);
                fr[i] = line[d];
            end
            end_cyc[d] = cyc;
            if (rst_cnt == r0) begin
                e = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : 16'hDEAD;
                check_eq($sformatf("frame%0d", d), fr, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0;
        for (int d = 0; d < 4; d++) set_we(d, 8'h00, 1'b0);
        #1 i_nrst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("reset_tx", line, 4'hF);
        check_eq("reset_rdy", get_rdy(0), 1'b1);
        check_eq("reset_busy", get_busy(0), 1'b0);
        check_eq("reset_srst", srst, 4'h0);
        @(posedge i_clk); #1 i_nrst = 1'b1;
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
        repeat (20) @(posedge i_clk);

        // 8N1 single byte from idle
        s0 = srst_cnt[0];
        @(negedge clk_tx);
        wr(0, 8'hA5, 1, 1, 1);
        wait_drain(0, 1000);
        check_eq("busy_in_stop", get_busy(0), 1'b1);
        @(posedge clk_tx);
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("busy_after_stop", get_busy(0), 1'b0);
        check_eq("srst_once", srst_cnt[0] - s0, 1);
        repeat (20) @(posedge i_clk);

        // back-to-back with a dropped third write
        s0 = srst_cnt[0];
        @(negedge clk_tx);
        wr(0, 8'h01, 1, 1, 1);
        repeat (4) @(posedge i_clk);
        wr(0, 8'hFF, 1, 1, 0);
        wr(0, 8'h55, 0, 0, 0);
        wait_drain(0, 1000);
        check_eq("b2b_no_gap", gap_cyc[0] <= 12, 1'b1);
        check_eq("b2b_srst_once", srst_cnt[0] - s0, 1);
        repeat (40) @(posedge i_clk);

        // parity even / odd, and 5-bit data with two stop bits
        for (int d = 1; d < 4; d++) begin
            @(negedge clk_tx);
            wr(d, (d == 3) ? 8'h1F : 8'h07, 1, 1, 1);
            wait_drain(d, 1000);
            repeat (40) @(posedge i_clk);
        end

        // reset in the middle of data bit 3
        @(negedge clk_tx);
        wr(0, 8'h00, 0, 1, 1);
        repeat (4) @(negedge clk_tx);
        #2;
        check_eq("bit3_low", line[0], 1'b0);
        i_nrst = 1'b0;
        #1;
        check_eq("abort_tx", line[0], 1'b1);
        check_eq("abort_rdy", get_rdy(0), 1'b1);
        check_eq("abort_busy", get_busy(0), 1'b0);
        repeat (3) @(posedge i_clk);
        #1 i_nrst = 1'b1;
        repeat (200) @(posedge i_clk);
        @(negedge clk_tx);
        wr(0, 8'h3C, 1, 1, 1);
        wait_drain(0, 1000);
        repeat (40) @(posedge i_clk);

        // frozen baud clock holds the start bit
        @(negedge clk_tx);
        run = 1'b0;
        wr(0, 8'h81, 1, 1, 1);
        repeat (100) @(posedge i_clk);
        #1;
        check_eq("stall_start", line[0], 1'b0);
        check_eq("stall_busy", get_busy(0), 1'b1);
        run = 1'b1;
        wait_drain(0, 1000);
        repeat (40) @(posedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
